mac_dot_ctrl: RTL and testbench

MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_core.sv | 39 +++
 rtl/mac_dot_ctrl.sv | 101 ++++++++++
 tb/tb_mac_dot_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product MAC controller: FSM encoding and
// default widths used by mac_core and mac_dot_ctrl.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mac_state_t;

    localparam int DEF_DATA_WIDTH = 2;
    localparam int DEF_ACC_WIDTH  = 8;
    localparam int DEF_LEN_WIDTH  = 4;

endpackage

// File: rtl/mac_core.sv
// Unsigned multiply-accumulate register: acc <= acc + a*b when enabled,
// synchronous clear, and the carry out of the (ACC_WIDTH+1)-bit sum.
module mac_core
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [ACC_WIDTH-1:0]  o_acc,
    output logic                  o_carry
);

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH:0]      w_sum;
    logic [ACC_WIDTH-1:0]    r_acc;

    assign w_prod  = i_a * i_b;
    // One extra bit so the caller can see the wrap as a carry.
    assign w_sum   = {1'b0, r_acc} + (ACC_WIDTH+1)'(w_prod);
    assign o_carry = w_sum[ACC_WIDTH];
    assign o_acc   = r_acc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mac_dot_ctrl.sv
// Dot-product controller: accepts len operand pairs over a valid/ready
// handshake, accumulates a*b in mac_core and returns the sum with sticky overflow.
module mac_dot_ctrl
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  overflow
);

    mac_state_t           r_state;
    mac_state_t           w_next;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic                 r_ovf;
    logic                 w_clr;
    logic                 w_en;
    logic                 w_carry;
    logic [ACC_WIDTH-1:0] w_acc;

    mac_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_a     (a),
        .i_b     (b),
        .o_acc   (w_acc),
        .o_carry (w_carry)
    );

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    w_en = 1'b1;
                    if (r_cnt == LEN_WIDTH'(1)) begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_clr) begin
                r_cnt <= len;
                r_ovf <= 1'b0;
            end else if (w_en) begin
                r_cnt <= r_cnt - 1'b1;
                r_ovf <= r_ovf | w_carry;
            end
        end
    end

    // Handshake outputs decode the state register only, so in_ready never
    // depends combinationally on in_valid.
    assign busy      = (r_state != ST_IDLE);
    assign in_ready  = (r_state == ST_RUN);
    assign res_valid = (r_state == ST_DONE);
    assign result    = w_acc;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Scoreboard bench for mac_dot_ctrl: driver pushes the expected sum/overflow
// per operation, a monitor compares whenever res_valid is presented.
module tb_mac_dot_ctrl;

    localparam int DW = 2;
    localparam int AW = 4;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [AW-1:0] result;
    logic          overflow;

    always #5 clk = ~clk;

    mac_dot_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic [AW-1:0] res;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rr_block = 0;
    int   va[16];
    int   vb[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer: random backpressure, or forced low for rr_block DONE cycles.
    initial begin
        forever begin
            tick();
            if (rr_block > 0) begin
                res_ready = 1'b0;
                if (res_valid) rr_block--;
            end else begin
                res_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: every presented result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            check("in_ready_outside_busy", int'(in_ready & ~busy), 0);
            check("in_ready_with_res_valid", int'(in_ready & res_valid), 0);
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_valid", 1, 0);
                end else begin
                    check("result", int'(result), int'(exp_q[0].res));
                    check("overflow", int'(overflow), int'(exp_q[0].ovf));
                    if (res_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 300) begin
            tick();
            t++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // One operation of L pairs from va/vb. gap: idle cycles between beats;
    // restart_len>0: pulse start with that len during RUN; abort_after>=0:
    // assert reset once that many beats have been accepted.
    task automatic run_op(input int L, input int gap, input int restart_len,
                          input int abort_after, output int t_start);
        int   sum = 0;
        int   t;
        bit   acc;
        exp_t e;
        wait_idle();
        for (int i = 0; i < L; i++) sum += va[i] * vb[i];
        if (abort_after < 0) begin
            e.res = AW'(sum);
            e.ovf = (sum > (1 << AW) - 1);
            exp_q.push_back(e);
        end
        start   = 1'b1;
        len     = LW'(L);
        t_start = cyc;
        tick();
        start = 1'b0;
        len   = LW'($urandom);
        for (int i = 0; i < L; i++) begin
            if (abort_after == i) begin
                reset    = 1'b0;
                start    = 1'b1;
                in_valid = 1'b1;
                tick();
                start    = 1'b0;
                in_valid = 1'b0;
                check("abort_busy", int'(busy), 0);
                check("abort_res_valid", int'(res_valid), 0);
                check("abort_in_ready", int'(in_ready), 0);
                check("abort_result", int'(result), 0);
                reset = 1'b1;
                return;
            end
            if (gap > 0 && i > 0) begin
                in_valid = 1'b0;
                repeat (gap) tick();
            end
            if (i == 1 && restart_len > 0) begin
                start = 1'b1;
                len   = LW'(restart_len);
            end
            in_valid = 1'b1;
            a = DW'(va[i]);
            b = DW'(vb[i]);
            t = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                tick();
                t++;
            end while (!acc && t < 50);
            start = 1'b0;
            if (!acc) check("beat_timeout", 1, 0);
        end
        in_valid = 1'b0;
        a = DW'($urandom);
        b = DW'($urandom);
    endtask

    initial begin
        int ts;
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts;
        // Reset state
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_overflow", int'(overflow), 0);
        reset = 1'b1;
        tick();

        // Three pairs, continuous valid: result 13 four cycles after start
        va[0] = 1; vb[0] = 2; va[1] = 3; vb[1] = 3; va[2] = 2; vb[2] = 1;
        rr_block = 2;
        run_op(3, 0, 0, -1, ts);
        check("latency_len3", cyc - ts, 4);
        check("res_valid_after_last", int'(res_valid), 1);

        // Wrap at 4 bits sets overflow: 9+9 = 18 -> 2
        va[0] = 3; vb[0] = 3; va[1] = 3; vb[1] = 3;
        run_op(2, 0, 0, -1, ts);

        // len = 0 goes straight to DONE with a zero result
        run_op(0, 0, 0, -1, ts);
        check("len0_done_next", int'(res_valid), 1);
        check("len0_in_ready", int'(in_ready), 0);

        // Stalled beats and a held-off consumer
        va[0] = 2; vb[0] = 3; va[1] = 1; vb[1] = 3;
        wait_idle();
        rr_block = 5;
        run_op(2, 3, 0, -1, ts);

        // Reset after one of three beats, then a fresh single-pair op
        va[0] = 3; vb[0] = 3; va[1] = 3; vb[1] = 3; va[2] = 3; vb[2] = 3;
        run_op(3, 0, 0, 1, ts);
        va[0] = 2; vb[0] = 2;
        run_op(1, 0, 0, -1, ts);

        // start during RUN with a different len is ignored
        va[0] = 1; vb[0] = 1; va[1] = 2; vb[1] = 1; va[2] = 1; vb[2] = 3;
        run_op(3, 0, 7, -1, ts);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            int L;
            L = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                va[i] = $urandom_range(0, 3);
                vb[i] = $urandom_range(0, 3);
            end
            run_op(L, $urandom_range(0, 2), 0, -1, ts);
        end

        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 300) begin
                tick();
                t++;
            end
        end
        check("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
